// File: rtl/window_3x3_ctrl_16.sv
// Pops one 3-pixel slice from three row FIFOs into a registered 3x3 window; pop in N gives valid in N+1.
// Window holds while valid && !ready and popping stalls; define WINDOW_STALL_CNT_EN for a stall counter.
module window_3x3_ctrl_16 #(
  parameter int PIX_W = 16,
  parameter int COL_W = 8,
  parameter int ROW_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stride2en,
  input  logic [COL_W-1:0]   row_len,
  input  logic [ROW_W-1:0]   num_rows,
  input  logic [3:0]         fifo_count0,
  input  logic [3:0]         fifo_count1,
  input  logic [3:0]         fifo_count2,
  input  logic [3*PIX_W-1:0] fifo_data0,
  input  logic [3*PIX_W-1:0] fifo_data1,
  input  logic [3*PIX_W-1:0] fifo_data2,
  output logic               fifo_pop,
  output logic               one_row_complete,
  output logic [9*PIX_W-1:0] window_data,
  output logic               window_valid,
  input  logic               window_ready,
  output logic               frame_done,
  output logic               busy,
  output logic [15:0]        stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_ROW_END = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

  state_t             state_q;
  logic [COL_W-1:0]   row_len_q;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   num_rows_q;
  logic [ROW_W-1:0]   row_q;
  logic [9*PIX_W-1:0] win_q;
  logic               win_vld_q;
  logic               orc_q;
  logic               done_q;
  logic               busy_q;

  logic counts_ok;
  logic slot_free;
  logic accept;
  logic pop_d;
  logic last_col;
  logic last_row;
  logic params_zero;
  logic unused_stride;

  // Stride is consumed by the FIFOs; the window controller behaves identically either way.
  assign unused_stride = stride2en;

  assign counts_ok   = (fifo_count0 >= 4'd3) && (fifo_count1 >= 4'd3) && (fifo_count2 >= 4'd3);
  assign accept      = win_vld_q && window_ready;
  assign slot_free   = !win_vld_q || window_ready;
  assign last_col    = (col_q == (row_len_q - COL_ONE));
  assign last_row    = (row_q == (num_rows_q - ROW_ONE));
  assign params_zero = (row_len == '0) || (num_rows == '0);

  // A restart in the same cycle would discard the popped slice, so start suppresses the pop.
  assign pop_d = (state_q == S_RUN) && !start && counts_ok && slot_free;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      row_len_q  <= '0;
      col_q      <= '0;
      num_rows_q <= '0;
      row_q      <= '0;
      win_q      <= '0;
      win_vld_q  <= 1'b0;
      orc_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else if (start) begin
      // Fresh frame or abort of a running one: no completion pulses for the old frame.
      row_len_q  <= row_len;
      num_rows_q <= num_rows;
      col_q      <= '0;
      row_q      <= '0;
      win_vld_q  <= 1'b0;
      orc_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b1;
      state_q    <= params_zero ? S_DONE : S_RUN;
    end else begin
      orc_q  <= 1'b0;
      done_q <= 1'b0;

      if (pop_d) begin
        win_q     <= {fifo_data2, fifo_data1, fifo_data0};
        win_vld_q <= 1'b1;
      end else if (accept) begin
        win_vld_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
        end
        S_RUN: begin
          if (pop_d) begin
            if (last_col) begin
              col_q   <= '0;
              state_q <= S_ROW_END;
            end else begin
              col_q <= col_q + COL_ONE;
            end
          end
        end
        S_ROW_END: begin
          // Row closes only once its final window has left the output register.
          if (!win_vld_q || accept) begin
            orc_q <= 1'b1;
            if (last_row) begin
              row_q   <= '0;
              state_q <= S_DONE;
            end else begin
              row_q   <= row_q + ROW_ONE;
              state_q <= S_RUN;
            end
          end
        end
        S_DONE: begin
          // Two cycles in DONE: the first arms frame_done, the second presents it.
          if (!done_q) begin
            done_q <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef WINDOW_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (start) begin
      stall_q <= '0;
    end else if (win_vld_q && !window_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0;
`endif

  assign fifo_pop         = pop_d;
  assign one_row_complete = orc_q;
  assign window_data      = win_q;
  assign window_valid     = win_vld_q;
  assign frame_done       = done_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_window_3x3_ctrl_16.sv
// Bench for window_3x3_ctrl_16: scoreboard on accepted windows, cycle bitmaps for frame sequences, pop-gating table.
module tb_window_3x3_ctrl_16;
  localparam int PIX_W = 16;
  localparam int SW    = 3 * PIX_W;
  localparam int WW    = 9 * PIX_W;

`ifdef WINDOW_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stride2en = 1'b0;
  logic [7:0]    row_len = '0;
  logic [7:0]    num_rows = '0;
  logic [3:0]    fifo_count0 = '0;
  logic [3:0]    fifo_count1 = '0;
  logic [3:0]    fifo_count2 = '0;
  logic [SW-1:0] fifo_data0 = '0;
  logic [SW-1:0] fifo_data1 = '0;
  logic [SW-1:0] fifo_data2 = '0;
  logic          window_ready = 1'b0;
  logic          fifo_pop;
  logic          one_row_complete;
  logic [WW-1:0] window_data;
  logic          window_valid;
  logic          frame_done;
  logic          busy;
  logic [15:0]   stall_cnt;

  always #5 clk = ~clk;

  window_3x3_ctrl_16 dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .stride2en        (stride2en),
    .row_len          (row_len),
    .num_rows         (num_rows),
    .fifo_count0      (fifo_count0),
    .fifo_count1      (fifo_count1),
    .fifo_count2      (fifo_count2),
    .fifo_data0       (fifo_data0),
    .fifo_data1       (fifo_data1),
    .fifo_data2       (fifo_data2),
    .fifo_pop         (fifo_pop),
    .one_row_complete (one_row_complete),
    .window_data      (window_data),
    .window_valid     (window_valid),
    .window_ready     (window_ready),
    .frame_done       (frame_done),
    .busy             (busy),
    .stall_cnt        (stall_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [WW-1:0] sb[$];

  task automatic check_w(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_n(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] rnd_slice();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[SW-1:0];
  endfunction

  // Accepted windows must match the slices presented when the pops happened, in order.
  always @(negedge clk) begin
    if (reset_n) begin
      if (window_valid && window_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_accept: window %0h accepted with nothing expected", window_data);
        end else begin
          check_w("sb_accept", window_data, sb.pop_front());
        end
      end
      if (fifo_pop) sb.push_back({fifo_data2, fifo_data1, fifo_data0});
    end
  end

  logic [15:0]   cap_pop, cap_vld, cap_orc, cap_fd, cap_busy;
  logic [WW-1:0] cap_win [16];
  logic [WW-1:0] drv_win [16];

  // Cycle 0 carries start; cycle abort_at carries a second start with rl2/nr2.
  task automatic run_frame(input logic [7:0] rl, input logic [7:0] nr, input int n,
                           input logic [15:0] rdy_mask, input int abort_at,
                           input logic [7:0] rl2, input logic [7:0] nr2);
    cap_pop = '0; cap_vld = '0; cap_orc = '0; cap_fd = '0; cap_busy = '0;
    @(posedge clk); #1;
    row_len  = rl;
    num_rows = nr;
    for (int i = 0; i < n; i++) begin
      start = (i == 0) || (i == abort_at);
      if (i == abort_at) begin
        row_len  = rl2;
        num_rows = nr2;
      end
      window_ready = rdy_mask[i];
      fifo_data0 = rnd_slice();
      fifo_data1 = rnd_slice();
      fifo_data2 = rnd_slice();
      drv_win[i] = {fifo_data2, fifo_data1, fifo_data0};
      @(negedge clk);
      cap_pop[i]  = fifo_pop;
      cap_vld[i]  = window_valid;
      cap_orc[i]  = one_row_complete;
      cap_fd[i]   = frame_done;
      cap_busy[i] = busy;
      cap_win[i]  = window_data;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [3:0] c0, c1, c2;
    logic       rdy;
    logic       exp_pop;
    logic       exp_vld;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [SW-1:0] d0, d1, d2;
    logic [WW-1:0] w;
    logic          seen_pulse;

    tbl[0]  = '{4'd0,  4'd0,  4'd0,  1'b1, 1'b0, 1'b0};
    tbl[1]  = '{4'd2,  4'd8,  4'd8,  1'b1, 1'b0, 1'b0};
    tbl[2]  = '{4'd8,  4'd2,  4'd8,  1'b1, 1'b0, 1'b0};
    tbl[3]  = '{4'd8,  4'd8,  4'd2,  1'b1, 1'b0, 1'b0};
    tbl[4]  = '{4'd3,  4'd3,  4'd3,  1'b0, 1'b1, 1'b0};
    tbl[5]  = '{4'd3,  4'd3,  4'd3,  1'b0, 1'b0, 1'b1};
    tbl[6]  = '{4'd15, 4'd15, 4'd15, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{4'd8,  4'd8,  4'd8,  1'b1, 1'b1, 1'b1};
    tbl[8]  = '{4'd8,  4'd8,  4'd8,  1'b1, 1'b1, 1'b1};
    tbl[9]  = '{4'd2,  4'd8,  4'd8,  1'b1, 1'b0, 1'b1};
    tbl[10] = '{4'd2,  4'd8,  4'd8,  1'b1, 1'b0, 1'b0};
    tbl[11] = '{4'd8,  4'd8,  4'd2,  1'b0, 1'b0, 1'b0};
    tbl[12] = '{4'd4,  4'd3,  4'd9,  1'b0, 1'b1, 1'b0};
    tbl[13] = '{4'd0,  4'd0,  4'd0,  1'b1, 1'b0, 1'b1};
    tbl[14] = '{4'd0,  4'd0,  4'd0,  1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_n("rst_valid", 32'(window_valid), 32'h0);
    check_n("rst_busy",  32'(busy), 32'h0);
    check_n("rst_pop",   32'(fifo_pop), 32'h0);
    check_n("rst_orc",   32'(one_row_complete), 32'h0);
    check_n("rst_fd",    32'(frame_done), 32'h0);
    check_n("rst_stall", 32'(stall_cnt), 32'h0);
    check_w("rst_win",   window_data, '0);
    reset_n = 1'b1;

    // Two rows of four windows, counts full, ready high
    fifo_count0 = 4'd8; fifo_count1 = 4'd8; fifo_count2 = 4'd8;
    run_frame(8'd4, 8'd2, 16, 16'hFFFF, -1, 8'd0, 8'd0);
    check_n("t1_pop",  32'(cap_pop),  32'h03DE);
    check_n("t1_vld",  32'(cap_vld),  32'h07BC);
    check_n("t1_orc",  32'(cap_orc),  32'h0840);
    check_n("t1_fd",   32'(cap_fd),   32'h1000);
    check_n("t1_busy", 32'(cap_busy), 32'h1FFE);

    // Backpressure for five cycles while the first window is held
    run_frame(8'd3, 8'd1, 16, 16'hFF83, -1, 8'd0, 8'd0);
    check_n("t2_pop", 32'(cap_pop), 32'h0182);
    for (int k = 2; k <= 6; k++) check_w($sformatf("t2_hold_%0d", k), cap_win[k], drv_win[1]);
    check_n("t2_orc", 32'(cap_orc), 32'h0400);
    check_n("t2_fd",  32'(cap_fd),  32'h0800);
    check_n("t2_stall", 32'(stall_cnt), STALL_EN ? 32'd5 : 32'd0);

    // Middle FIFO short by one entry, then topped up
    @(posedge clk); #1;
    row_len = 8'd1; num_rows = 8'd1; start = 1'b1; window_ready = 1'b1;
    fifo_count0 = 4'd8; fifo_count1 = 4'd2; fifo_count2 = 4'd8;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_n($sformatf("t3_nopop_%0d", k), 32'(fifo_pop), 32'h0);
      @(posedge clk); #1;
      start = 1'b0;
    end
    d0 = 48'h0003_0002_0001;
    d1 = 48'h0013_0012_0011;
    d2 = 48'h0023_0022_0021;
    fifo_data0 = d0; fifo_data1 = d1; fifo_data2 = d2; fifo_count1 = 4'd3;
    @(negedge clk);
    check_n("t3_pop", 32'(fifo_pop), 32'h1);
    @(posedge clk); #1;
    fifo_count1 = 4'd2;
    fifo_data0 = rnd_slice();
    @(negedge clk);
    check_n("t3_vld", 32'(window_valid), 32'h1);
    w = 144'h0023_0022_0021_0013_0012_0011_0003_0002_0001;
    check_w("t3_win", window_data, w);
    check_w("t3_top", WW'(window_data[SW-1:0]), WW'(d0));
    repeat (4) @(posedge clk);
    #1;
    check_n("t3_idle", 32'(busy), 32'h0);

    // Last window of the row held three cycles before acceptance
    fifo_count0 = 4'd8; fifo_count1 = 4'd8; fifo_count2 = 4'd8;
    run_frame(8'd2, 8'd1, 12, 16'hFFC7, -1, 8'd0, 8'd0);
    check_n("t4_vld", 32'(cap_vld), 32'h007C);
    check_n("t4_orc", 32'(cap_orc), 32'h0080);
    check_n("t4_fd",  32'(cap_fd),  32'h0100);

    // Restart at col 2 of a two-row frame
    run_frame(8'd4, 8'd2, 16, 16'hFFFF, 3, 8'd3, 8'd1);
    check_n("t5_pop",  32'(cap_pop),  32'h0076);
    check_n("t5_vld",  32'(cap_vld),  32'h00EC);
    check_n("t5_orc",  32'(cap_orc),  32'h0100);
    check_n("t5_fd",   32'(cap_fd),   32'h0200);
    check_n("t5_busy", 32'(cap_busy), 32'h03FE);

    // Degenerate frames
    run_frame(8'd0, 8'd5, 6, 16'hFFFF, -1, 8'd0, 8'd0);
    check_n("t6_busy", 32'(cap_busy), 32'h0006);
    check_n("t6_fd",   32'(cap_fd),   32'h0004);
    check_n("t6_pop",  32'(cap_pop),  32'h0000);
    run_frame(8'd3, 8'd0, 6, 16'hFFFF, -1, 8'd0, 8'd0);
    check_n("t6b_busy", 32'(cap_busy), 32'h0006);
    check_n("t6b_pop",  32'(cap_pop),  32'h0000);

    // Pop gating table on a long row
    @(posedge clk); #1;
    fifo_count0 = 4'd0; fifo_count1 = 4'd0; fifo_count2 = 4'd0;
    row_len = 8'd200; num_rows = 8'd1; start = 1'b1; window_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    foreach (tbl[i]) begin
      fifo_count0 = tbl[i].c0; fifo_count1 = tbl[i].c1; fifo_count2 = tbl[i].c2;
      window_ready = tbl[i].rdy;
      fifo_data0 = rnd_slice(); fifo_data1 = rnd_slice(); fifo_data2 = rnd_slice();
      @(negedge clk);
      check_n($sformatf("tbl_pop_%0d", i), 32'(fifo_pop), 32'(tbl[i].exp_pop));
      check_n($sformatf("tbl_vld_%0d", i), 32'(window_valid), 32'(tbl[i].exp_vld));
      @(posedge clk); #1;
    end
    check_n("tbl_stall", 32'(stall_cnt), STALL_EN ? 32'd2 : 32'd0);
    check_n("sb_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the middle of a frame with a window held
    fifo_count0 = 4'd8; fifo_count1 = 4'd8; fifo_count2 = 4'd8;
    window_ready = 1'b0; row_len = 8'd4; num_rows = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_n("arst_valid", 32'(window_valid), 32'h0);
    check_n("arst_busy",  32'(busy), 32'h0);
    check_n("arst_pop",   32'(fifo_pop), 32'h0);
    check_n("arst_stall", 32'(stall_cnt), 32'h0);
    check_w("arst_win",   window_data, '0);
    sb.delete();
    window_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    seen_pulse = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      seen_pulse = seen_pulse | one_row_complete | frame_done | busy | fifo_pop;
    end
    check_n("arst_no_pulse", 32'(seen_pulse), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
